seg_serial_rx: RTL and testbench
================================

# seg_serial_rx

Serial-to-parallel receiver for the shift-register stream the board display driver emits on its serial clock/data/latch pins (the SEGLED and LED buses). It oversamples the three serial lines in the CPU/display clock domain, shifts in one frame, and commits it as a parallel word on the latch edge. It gives the simulation bench and the on-chip debug path a readback of what the display is actually being sent.

## Interface
- WIDTH, 64: bits per frame (64 for the 8-digit segment bus, 16 for the LED bus).
- CNT_W, 16: width of the good-frame counter.
- clk  input  1  sampling clock; same domain as the display driver clock (25 MHz clk_disp).
- rstn  input  1  asynchronous active-low reset.
- ser_clk  input  1  serial shift clock from the transmitter; idle low.
- ser_do  input  1  serial data, MSB of the frame first.
- ser_pen  input  1  latch/enable; a rising edge commits the frame.
- data  output  WIDTH  last committed frame; bit WIDTH-1 is the first bit received.
- valid  output  1  one-cycle pulse when `data` updates.
- frame_err  output  1  one-cycle pulse when a latch arrives with a bit count ≠ WIDTH.
- frame_cnt  output  CNT_W  count of good frames, modulo 2^CNT_W.

## Operation
- Synchronizers:
  - ser_clk, ser_do and ser_pen each pass through two flops (s1, s2).
  - A third flop (s3) holds the previous s2 value for edge detection.
  - rise_clk = s2_clk & ~s3_clk; rise_pen = s2_pen & ~s3_pen.
  - The data bit sampled on a shift is s2_do.
- Shift, on rise_clk with s2_pen = 0:
  - sh <= {sh[WIDTH-2:0], s2_do}.
  - bitcnt <= bitcnt + 1, saturating at WIDTH+1.
- rise_clk while s2_pen = 1 is ignored: no shift, no count.
- Commit, on rise_pen:
  - If bitcnt = WIDTH: data <= sh, valid = 1, frame_cnt += 1 (wraps from all-ones to 0).
  - Otherwise: frame_err = 1; data, valid and frame_cnt are unchanged.
  - In both cases bitcnt <= 0. `sh` is not cleared.
- Overlength frame: after more than WIDTH shifts, `sh` holds only the last WIDTH bits and bitcnt sits at WIDTH+1, so the commit reports frame_err.
- Simultaneous rise_clk and rise_pen in the same cycle:
  - rise_pen requires s3_pen = 0, so the shift is taken first.
  - The commit uses the shifted value and the incremented count (bit included).
- The falling edges of ser_pen and ser_clk have no effect beyond updating the synchronizers.
- Reset (rstn low, asynchronous):
  - s1/s2/s3 of all lines, sh, bitcnt, data, frame_cnt all go to 0; valid = 0; frame_err = 0.
  - Reset mid-frame discards the partial frame. After release, the first latch edge commits only if WIDTH new shifts were seen.
- Control: two states, IDLE (bitcnt = 0) and SHIFT (bitcnt > 0).
  - IDLE→SHIFT on the first shift.
  - SHIFT→IDLE on rise_pen.
  - rise_pen in IDLE yields frame_err (0 ≠ WIDTH).

## Timing
- Input change → s2 after the 2nd clk rising edge. The edge is detected combinationally in the following cycle. The action is registered on the 3rd edge.
- Latency: ser_pen rising → valid/frame_err high in the cycle after the 3rd clk edge; data is valid in that same cycle.
- valid and frame_err are exactly one cycle wide. They are mutually exclusive and registered (no combinational output paths).
- Transmitter constraints:
  - ser_clk high and low phases ≥ 3 clk periods each.
  - ser_do stable from 3 clk before to 1 clk after the ser_clk rising edge.
  - ser_pen stays low ≥ 3 clk after the last ser_clk rise.
  - Minimum spacing between ser_pen rising edges is 6 clk.
- Back-to-back frames: a new shift may occur in the cycle immediately after a commit.
- Outputs hold their values between events.

## Test plan
- Reset values: drive rstn low mid-simulation with ser_pen toggling -> data = 0, frame_cnt = 0, valid = 0, frame_err = 0 immediately, without waiting for a clk edge.
- Nominal, WIDTH=64: shift 64'hC0F9_A4B0_9992_82F8 MSB first (4 clk per phase), then raise ser_pen -> single valid pulse, data = 64'hC0F9_A4B0_9992_82F8, frame_cnt = 1; pen-rise-to-valid latency = 3 clk edges.
- Short frame: 63 shifts then latch -> frame_err pulse, data and frame_cnt unchanged. Overlength: 65 shifts of 1 then latch -> frame_err, data unchanged.
- Simultaneous edges: drive ser_clk (64th bit = 1) and ser_pen high on the same clk edge -> valid pulse, data[0] = 1, no frame_err.
- Gating and wrap:
  - ser_clk pulses while ser_pen is high -> bitcnt unchanged.
  - WIDTH=16, CNT_W=2: five good frames 16'h00FF, 16'hA5A5, ... -> frame_cnt sequence 1, 2, 3, 0, 1.
- Reset mid-frame: 30 shifts, pulse rstn low, then 64 fresh shifts of 64'h0123_4567_89AB_CDEF and latch -> data = 64'h0123_4567_89AB_CDEF, frame_cnt = 1.

Source files
------------

// File: rtl/seg_serial_rx_if.sv
// Serial display-bus interface: the three transmitter lines plus the
// receiver's parallel readback.
interface seg_serial_rx_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             ser_clk;
  logic             ser_do;
  logic             ser_pen;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output ser_clk, ser_do, ser_pen,
    input  data, valid, frame_err, frame_cnt
  );

  modport slave (
    input  ser_clk, ser_do, ser_pen,
    output data, valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/seg_serial_rx.sv
// Oversampling serial-to-parallel receiver for the display shift-register bus;
// commits one WIDTH-bit frame per latch rising edge.
module seg_serial_rx #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rstn,
  seg_serial_rx_if.slave bus
);

  localparam int              BC_W    = $clog2(WIDTH + 2);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(WIDTH);
  localparam logic [BC_W-1:0] BC_SAT  = BC_W'(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // bit0 = s1, bit1 = s2, bit2 = s3 (edge-detect history)
  logic [2:0]       clk_sync_q, pen_sync_q;
  logic [1:0]       do_sync_q;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  state_t           state_q, state_d;

  logic rise_clk, rise_pen, shift;

  assign rise_clk = clk_sync_q[1] & ~clk_sync_q[2];
  assign rise_pen = pen_sync_q[1] & ~pen_sync_q[2];
  // A clock edge landing with the latch edge still counts: the latch was low
  // the cycle before, so the bit belongs to the frame being committed.
  assign shift    = rise_clk & (~pen_sync_q[1] | ~pen_sync_q[2]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_q <= '0;
      pen_sync_q <= '0;
      do_sync_q  <= '0;
      sh_q       <= '0;
      bitcnt_q   <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      state_q    <= IDLE;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], bus.ser_clk};
      pen_sync_q <= {pen_sync_q[1:0], bus.ser_pen};
      do_sync_q  <= {do_sync_q[0], bus.ser_do};
      sh_q       <= sh_d;
      bitcnt_q   <= bitcnt_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    state_d  = state_q;

    if (shift) begin
      sh_d = {sh_q[WIDTH-2:0], do_sync_q[1]};
      if (bitcnt_q != BC_SAT) bitcnt_d = bitcnt_q + BC_W'(1);
    end

    case (state_q)
      IDLE:    if (shift) state_d = SHIFT;
      SHIFT:   state_d = SHIFT;
      default: state_d = IDLE;
    endcase

    // Commit sees the post-shift frame so a coincident last bit is included.
    if (rise_pen) begin
      if (bitcnt_d == BC_FULL) begin
        data_d  = sh_d;
        valid_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
      bitcnt_d = '0;
      state_d  = IDLE;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = err_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_seg_serial_rx.sv
// Scoreboard bench: a 64-bit/16-bit-counter receiver and a 16-bit/2-bit-counter
// receiver driven with directed frames; a negedge monitor checks every output event.
module tb_seg_serial_rx;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic sc[2], sd[2], sp[2];

  seg_serial_rx_if #(.WIDTH(64), .CNT_W(16)) a_if ();
  seg_serial_rx_if #(.WIDTH(16), .CNT_W(2))  b_if ();

  assign a_if.ser_clk = sc[0];
  assign a_if.ser_do  = sd[0];
  assign a_if.ser_pen = sp[0];
  assign b_if.ser_clk = sc[1];
  assign b_if.ser_do  = sd[1];
  assign b_if.ser_pen = sp[1];

  seg_serial_rx #(.WIDTH(64), .CNT_W(16)) dut_a (.clk(clk), .rstn(rstn), .bus(a_if.slave));
  seg_serial_rx #(.WIDTH(16), .CNT_W(2))  dut_b (.clk(clk), .rstn(rstn), .bus(b_if.slave));

  typedef struct {
    logic        err;
    logic [63:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(int sel, logic b);
    sd[sel] = b;
    tick(4);
    sc[sel] = 1'b1;
    tick(4);
    sc[sel] = 1'b0;
  endtask

  task automatic send_bits(int sel, logic [63:0] v, int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(sel, v[i]);
    tick(4);
  endtask

  task automatic latch(int sel);
    sp[sel] = 1'b1;
    tick(5);
    sp[sel] = 1'b0;
    tick(4);
  endtask

  // Monitor: every valid/frame_err pulse must match the next expected event.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && (a_if.valid || a_if.frame_err)) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_bad++;
        $display("FAIL a_unexpected: valid=%0b err=%0b data=%h", a_if.valid, a_if.frame_err, a_if.data);
      end else begin
        e = qa.pop_front();
        if (a_if.valid !== !e.err || a_if.frame_err !== e.err ||
            a_if.data !== e.data || a_if.frame_cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL a_event: got v=%0b e=%0b data=%h cnt=%0d expected v=%0b e=%0b data=%h cnt=%0d",
                   a_if.valid, a_if.frame_err, a_if.data, a_if.frame_cnt, !e.err, e.err, e.data, e.cnt);
        end
      end
    end
    if (rstn && (b_if.valid || b_if.frame_err)) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL b_unexpected: valid=%0b err=%0b data=%h", b_if.valid, b_if.frame_err, b_if.data);
      end else begin
        e = qb.pop_front();
        if (b_if.valid !== !e.err || b_if.frame_err !== e.err ||
            b_if.data !== e.data[15:0] || b_if.frame_cnt !== e.cnt[1:0]) begin
          n_bad++;
          $display("FAIL b_event: got v=%0b e=%0b data=%h cnt=%0d expected v=%0b e=%0b data=%h cnt=%0d",
                   b_if.valid, b_if.frame_err, b_if.data, b_if.frame_cnt, !e.err, e.err, e.data[15:0], e.cnt[1:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a_data;
    logic [15:0] a_cnt;
    logic [15:0] b_frames[5];
    logic [1:0]  b_cnt_exp[5];

    b_frames  = '{16'h00FF, 16'hA5A5, 16'h1234, 16'hFFFF, 16'h0F0F};
    b_cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    for (int s = 0; s < 2; s++) begin
      sc[s] = 1'b0; sd[s] = 1'b0; sp[s] = 1'b0;
    end
    rstn = 1'b0;
    #12;
    chk("rst_data", a_if.data, 64'd0);
    chk("rst_cnt", 64'(a_if.frame_cnt), 64'd0);
    chk("rst_valid", 64'(a_if.valid), 64'd0);
    chk("rst_err", 64'(a_if.frame_err), 64'd0);
    tick(2);
    rstn = 1'b1;
    tick(2);

    // Nominal frame with pen-to-valid latency
    a_data = 64'hC0F9_A4B0_9992_82F8;
    a_cnt  = 16'd1;
    send_bits(0, a_data, 64);
    qa.push_back('{1'b0, a_data, a_cnt});
    sp[0] = 1'b1;
    tick(2);
    chk("lat_before", 64'(a_if.valid), 64'd0);
    tick(1);
    chk("lat_valid", 64'(a_if.valid), 64'd1);
    chk("lat_data", a_if.data, 64'hC0F9_A4B0_9992_82F8);
    tick(2);
    sp[0] = 1'b0;
    tick(4);

    // Short frame
    send_bits(0, 64'h1234_5678_9ABC_DEF0, 63);
    qa.push_back('{1'b1, a_data, a_cnt});
    latch(0);

    // Overlength frame
    send_bits(0, '1, 64);
    shift_bit(0, 1'b1);
    tick(4);
    qa.push_back('{1'b1, a_data, a_cnt});
    latch(0);

    // Last clock edge coincident with latch edge
    send_bits(0, 64'h8000_0000_0000_0001 >> 1, 63);
    a_data = 64'h8000_0000_0000_0001;
    a_cnt  = 16'd2;
    qa.push_back('{1'b0, a_data, a_cnt});
    sd[0] = 1'b1;
    tick(4);
    sc[0] = 1'b1;
    sp[0] = 1'b1;
    tick(4);
    sc[0] = 1'b0;
    tick(4);
    sp[0] = 1'b0;
    tick(4);
    chk("simul_bit0", 64'(a_if.data[0]), 64'd1);

    // Clock pulses while latch is high must not count
    send_bits(0, 64'h1122_3344_5566_7788, 64);
    a_data = 64'h1122_3344_5566_7788;
    a_cnt  = 16'd3;
    qa.push_back('{1'b0, a_data, a_cnt});
    sp[0] = 1'b1;
    tick(5);
    for (int k = 0; k < 3; k++) shift_bit(0, 1'b1);
    tick(4);
    sp[0] = 1'b0;
    tick(4);
    send_bits(0, 64'h0AAA_AAAA_AAAA_AAAA, 61);
    qa.push_back('{1'b1, a_data, a_cnt});
    latch(0);

    // 16-bit receiver, 2-bit counter wrap
    for (int f = 0; f < 5; f++) begin
      send_bits(1, 64'(b_frames[f]), 16);
      qb.push_back('{1'b0, 64'(b_frames[f]), 16'(b_cnt_exp[f])});
      latch(1);
    end

    // Asynchronous reset mid-frame while the latch line toggles
    send_bits(0, '1, 30);
    sp[0] = 1'b1;
    #3;
    rstn = 1'b0;
    #1;
    chk("mid_rst_data", a_if.data, 64'd0);
    chk("mid_rst_cnt", 64'(a_if.frame_cnt), 64'd0);
    chk("mid_rst_valid", 64'(a_if.valid), 64'd0);
    chk("mid_rst_err", 64'(a_if.frame_err), 64'd0);
    chk("mid_rst_b_data", 64'(b_if.data), 64'd0);
    chk("mid_rst_b_cnt", 64'(b_if.frame_cnt), 64'd0);
    tick(2);
    sp[0] = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(3);
    a_data = 64'h0123_4567_89AB_CDEF;
    a_cnt  = 16'd1;
    send_bits(0, a_data, 64);
    qa.push_back('{1'b0, a_data, a_cnt});
    latch(0);
    chk("post_rst_data", a_if.data, 64'h0123_4567_89AB_CDEF);
    chk("post_rst_cnt", 64'(a_if.frame_cnt), 64'd1);

    for (int i = 0; i < 50 && (qa.size() + qb.size()) > 0; i++) tick(1);
    chk("queues_drained", 64'(qa.size() + qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
